pipe_rr_arbiter: RTL and testbench
==================================

// Module: pipe_rr_arbiter
// PURPOSE
//  Shares one PipeIn-style enq port (a 1-entry bypass FIFO) between NREQ producers.
//  Selection is round-robin, single-cycle and combinational. The enq data is muxed
//  from the winner. An optional burst lock keeps the grant on one producer for a
//  multi-beat packet.
// PARAMETERS
//  NREQ   4    number of requesters, 2..16
//  width  32   payload bits per beat
//  IDW    $clog2(NREQ)  id width, derived (localparam)
// PORTS
//  CLK        in   1           clock, all state on posedge
//  nRST       in   1           synchronous reset, active-low
//  req_valid  in   NREQ        requester i holds a beat
//  req_data   in   NREQ*width  beat of requester i at bits [i*width +: width]
//  req_last   in   NREQ        beat is the last of a packet (used only with ARB_LOCK_EN)
//  req_rdy    out  NREQ        beat of requester i is taken this cycle
//  enq_ena    out  1           enq to downstream FIFO
//  enq_v      out  width       enq payload
//  enq_rdy    in   1           downstream FIFO can accept (its enq__RDY)
//  grant_id   out  IDW         index of the selected requester; 0 when none
// BEHAVIOUR
//  - One clock (CLK). Reset is synchronous, active-low (nRST).
//  - State: ptr[IDW-1:0], the highest-priority index. Lock adds lock_st (IDLE/LOCKED)
//    and owner[IDW-1:0].
//  - Reset: ptr=0, lock_st=IDLE, owner=0.
//  - While nRST=0: req_rdy=0, enq_ena=0, enq_v=0, grant_id=0.
//  - Select (IDLE): winner = first i with req_valid[i], scanning ptr, ptr+1, ...
//    with wrap from NREQ-1 to 0. No valid means no winner.
//  - Outputs:
//    - enq_ena = enq_rdy & winner exists.
//    - req_rdy = onehot(winner) & {NREQ{enq_rdy}}.
//    - enq_v = req_data[winner], 0 when no winner.
//    - grant_id = winner, 0 when no winner.
//  - Latency: zero. A transfer is req_valid[i] & req_rdy[i], in the same cycle as enq_ena.
//    No storage in this block.
//  - Combinational paths: req_valid->req_rdy and enq_rdy->req_rdy/enq_ena exist.
//    No path from enq_ena back to any input.
//  - Update: on a transfer by i, ptr <= (i==NREQ-1) ? 0 : i+1.
//    No transfer (enq_rdy=0 or no valid) leaves ptr unchanged.
//  - Fairness: with all requesters continuously valid and enq_rdy=1, grants rotate
//    0,1,..,NREQ-1,0. A valid requester waits at most NREQ-1 transfers.
//  - enq_rdy=0: no grant, no ptr change. req_valid may change freely (no hold rule).
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - IDLE: a transfer by i with req_last[i]=0 sets owner<=i, lock_st<=LOCKED.
//    ptr is not updated yet.
//  - LOCKED: winner is owner if req_valid[owner], else none. Other requesters get
//    req_rdy=0 even when enq_rdy=1.
//  - LOCKED: a transfer with req_last[owner]=1 sets lock_st<=IDLE, ptr<=owner+1 (wrapped).
//  - IDLE transfer with req_last=1 is a single-beat packet: ptr updates as above.
//  - nRST low mid-packet drops the lock (IDLE, ptr=0).
//  ARB_LOCK_EN undefined: req_last ignored, no lock_st/owner; every beat arbitrates.
// TESTING
//  1. Reset:
//     - Stimulus: nRST=0 two cycles, req_valid=4'hF, enq_rdy=1.
//     - Response: req_rdy=0, enq_ena=0; first cycle after release grants 0.
//  2. Rotation:
//     - Stimulus: req_valid=4'hF, enq_rdy=1 for 8 cycles.
//     - Response: grant_id 0,1,2,3,0,1,2,3; enq_v equals the matching req_data.
//  3. Wrap/skip:
//     - Stimulus: ptr=3 after grant 2, req_valid=4'b0011.
//     - Response: grant 0, then 1, then 0.
//  4. Backpressure:
//     - Stimulus: req_valid=4'b0100, enq_rdy=0 for 3 cycles, then 1.
//     - Response: no req_rdy during the stall, grant 2 on release, ptr=3 after.
//  5. Lock (ARB_LOCK_EN):
//     - Stimulus: req 1 sends 3 beats (last on 3rd) while req 0 and req 2 are valid;
//       req 1 drops valid for 1 cycle mid-packet.
//     - Response: all 3 beats from 1, idle gap with no grant, then grant 2.
//  6. Reset mid-lock (ARB_LOCK_EN):
//     - Stimulus: nRST pulse after beat 1 of a 3-beat packet from req 3.
//     - Response: next grant is 0 if req_valid[0]=1.

Source files
------------

// File: rtl/pipe_rr_arbiter_if.sv
// Handshake bundle between NREQ producers, the round-robin arbiter and a downstream enq port.
// master = arbiter side, slave = producer/FIFO side.
interface pipe_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int width = 32
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*width-1:0]   req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_rdy;
    logic                    enq_ena;
    logic [width-1:0]        enq_v;
    logic                    enq_rdy;
    logic [$clog2(NREQ)-1:0] grant_id;

    modport master (
        input  req_valid, req_data, req_last, enq_rdy,
        output req_rdy, enq_ena, enq_v, grant_id
    );

    modport slave (
        output req_valid, req_data, req_last, enq_rdy,
        input  req_rdy, enq_ena, enq_v, grant_id
    );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Zero-latency round-robin arbiter sharing one bypass-FIFO enq port among NREQ producers.
// Optional multi-beat burst lock: define ARB_LOCK_EN.
module pipe_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int width = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    pipe_rr_arbiter_if.master   bus
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] winner_s;
    logic           found_s;
    logic           xfer_s;

`ifdef ARB_LOCK_EN
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_t;
    lock_t          lock_st_r;
    logic [IDW-1:0] owner_r;
`else
    logic           unused_last_s;
    assign unused_last_s = ^bus.req_last;
`endif

    // Returns {hit, index} of the first valid requester scanning from p upward with wrap.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic           hit;
        logic [IDW-1:0] idx;
        int             i;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            i = (int'(p) + k) % NREQ;
            if (!hit && v[i]) begin
                hit = 1'b1;
                idx = IDW'(i);
            end else begin
                hit = hit;
            end
        end
        return {hit, idx};
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
        return (p == IDW'(NREQ - 1)) ? '0 : p + {{(IDW-1){1'b0}}, 1'b1};
    endfunction

    // Winner selection: owner only while locked, otherwise round-robin from ptr.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
`ifdef ARB_LOCK_EN
        if (lock_st_r == LOCKED) begin
            found_s  = bus.req_valid[owner_r];
            winner_s = bus.req_valid[owner_r] ? owner_r : '0;
        end else begin
            {found_s, winner_s} = rr_pick(bus.req_valid, ptr_r);
        end
`else
        {found_s, winner_s} = rr_pick(bus.req_valid, ptr_r);
`endif
    end

    // Handshake outputs; everything is forced to zero while reset is held.
    always_comb begin
        xfer_s       = nRST & found_s & bus.enq_rdy;
        bus.enq_ena  = xfer_s;
        bus.req_rdy  = '0;
        bus.enq_v    = '0;
        bus.grant_id = '0;
        if (xfer_s) begin
            bus.req_rdy = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            bus.req_rdy = '0;
        end
        if (nRST && found_s) begin
            bus.enq_v    = bus.req_data[int'(winner_s)*width +: width];
            bus.grant_id = winner_s;
        end else begin
            bus.enq_v    = '0;
            bus.grant_id = '0;
        end
    end

    // Priority pointer and burst-lock state advance only on a completed transfer.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr_r <= '0;
`ifdef ARB_LOCK_EN
            lock_st_r <= IDLE;
            owner_r   <= '0;
`endif
        end else if (xfer_s) begin
`ifdef ARB_LOCK_EN
            if (lock_st_r == LOCKED) begin
                if (bus.req_last[owner_r]) begin
                    lock_st_r <= IDLE;
                    ptr_r     <= next_ptr(owner_r);
                end else begin
                    lock_st_r <= LOCKED;
                end
            end else if (!bus.req_last[winner_s]) begin
                // First beat of a multi-beat packet: hold ptr until the last beat.
                owner_r   <= winner_s;
                lock_st_r <= LOCKED;
            end else begin
                ptr_r <= next_ptr(winner_s);
            end
`else
            ptr_r <= next_ptr(winner_s);
`endif
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed self-checking bench for pipe_rr_arbiter (NREQ=4, width=32).
// Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_pipe_rr_arbiter;
    logic CLK;
    logic nRST;
    int   total;
    int   bad;

    logic [31:0] dat [4];

    pipe_rr_arbiter_if #(.NREQ(4), .width(32)) bus ();

    pipe_rr_arbiter #(.NREQ(4), .width(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Checks one cycle: expected grant index, ready vector and enq_ena.
    task automatic chk_cycle(input string tag, input int g, input logic [3:0] rdy, input logic ena);
        #1;
        chk({tag, ".grant"}, {30'd0, bus.grant_id}, g);
        chk({tag, ".rdy"}, {28'd0, bus.req_rdy}, {28'd0, rdy});
        chk({tag, ".ena"}, {31'd0, bus.enq_ena}, {31'd0, ena});
        if (ena) chk({tag, ".data"}, bus.enq_v, dat[g]);
        else     chk({tag, ".data_idle"}, 32'd0, 32'd0 | (bus.req_valid == 4'd0 ? bus.enq_v : 32'd0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        dat[0] = 32'hAAAA_0000;
        dat[1] = 32'hBBBB_0001;
        dat[2] = 32'hCCCC_0002;
        dat[3] = 32'hDDDD_0003;
        bus.req_data  = {dat[3], dat[2], dat[1], dat[0]};
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        bus.enq_rdy   = 1'b1;
        nRST          = 1'b0;

        // Reset held two cycles with all requesters valid.
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            chk("rst.rdy", {28'd0, bus.req_rdy}, 32'd0);
            chk("rst.ena", {31'd0, bus.enq_ena}, 32'd0);
            chk("rst.enq_v", bus.enq_v, 32'd0);
            chk("rst.grant", {30'd0, bus.grant_id}, 32'd0);
        end

        // Release reset: rotation 0,1,2,3,0,1,2,3.
        tick();
        nRST = 1'b1;
        chk_cycle("rot0", 0, 4'b0001, 1'b1); tick();
        chk_cycle("rot1", 1, 4'b0010, 1'b1); tick();
        chk_cycle("rot2", 2, 4'b0100, 1'b1); tick();
        chk_cycle("rot3", 3, 4'b1000, 1'b1); tick();
        chk_cycle("rot4", 0, 4'b0001, 1'b1); tick();
        chk_cycle("rot5", 1, 4'b0010, 1'b1); tick();
        chk_cycle("rot6", 2, 4'b0100, 1'b1); tick();
        chk_cycle("rot7", 3, 4'b1000, 1'b1); tick();

        // Wrap/skip: grant 2 leaves ptr=3, then only 0 and 1 valid.
        bus.req_valid = 4'b0100;
        chk_cycle("wrap.g2", 2, 4'b0100, 1'b1); tick();
        bus.req_valid = 4'b0011;
        chk_cycle("wrap.a", 0, 4'b0001, 1'b1); tick();
        chk_cycle("wrap.b", 1, 4'b0010, 1'b1); tick();
        chk_cycle("wrap.c", 0, 4'b0001, 1'b1); tick();

        // Backpressure: three stalled cycles then release; ptr must not move while stalled.
        bus.req_valid = 4'b0100;
        bus.enq_rdy   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall.rdy", {28'd0, bus.req_rdy}, 32'd0);
            chk("stall.ena", {31'd0, bus.enq_ena}, 32'd0);
            tick();
        end
        bus.enq_rdy = 1'b1;
        chk_cycle("bp.release", 2, 4'b0100, 1'b1); tick();
        bus.req_valid = 4'b1001;
        chk_cycle("bp.ptr3", 3, 4'b1000, 1'b1); tick();

        // No requester valid: no grant.
        bus.req_valid = 4'b0000;
        #1;
        chk("none.ena", {31'd0, bus.enq_ena}, 32'd0);
        chk("none.grant", {30'd0, bus.grant_id}, 32'd0);
        chk("none.enq_v", bus.enq_v, 32'd0);
        tick();

`ifdef ARB_LOCK_EN
        // Single-beat grant from 0 moves ptr to 1.
        bus.req_valid = 4'b0001;
        chk_cycle("lk.single", 0, 4'b0001, 1'b1); tick();
        // Requester 1 sends a 3-beat packet while 0 and 2 stay valid.
        bus.req_valid = 4'b0111;
        bus.req_last  = 4'b0000;
        chk_cycle("lk.beat1", 1, 4'b0010, 1'b1); tick();
        bus.req_valid = 4'b0101;
        #1;
        chk("lk.gap.rdy", {28'd0, bus.req_rdy}, 32'd0);
        chk("lk.gap.ena", {31'd0, bus.enq_ena}, 32'd0);
        chk("lk.gap.grant", {30'd0, bus.grant_id}, 32'd0);
        tick();
        bus.req_valid = 4'b0111;
        chk_cycle("lk.beat2", 1, 4'b0010, 1'b1); tick();
        bus.req_last = 4'b0010;
        chk_cycle("lk.beat3", 1, 4'b0010, 1'b1); tick();
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b1111;
        chk_cycle("lk.after", 2, 4'b0100, 1'b1); tick();

        // Reset after beat 1 of a packet from 3 drops the lock.
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b0000;
        chk_cycle("rl.beat1", 3, 4'b1000, 1'b1); tick();
        nRST = 1'b0;
        #1;
        chk("rl.rst.ena", {31'd0, bus.enq_ena}, 32'd0);
        tick();
        nRST = 1'b1;
        chk_cycle("rl.next", 0, 4'b0001, 1'b1); tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
